// File: rtl/clock_divider_seq.sv
// clock_divider_seq
// Steps an external clock divider through a small table of scale values.
// Each table entry is held for a programmable number of divided-clock
// periods. A new scale is applied only in the cycle after a div_tick, so the
// divider always sees the change on an output-period boundary.
// The sequence can run once or loop, and can be stopped at the next period
// boundary.

module clock_divider_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_we,
    input  logic [1:0] cfg_addr,
    input  logic [7:0] cfg_data,
    input  logic [1:0] last_idx,
    input  logic [7:0] dwell,
    input  logic       loop_en,
    input  logic       start,
    input  logic       stop,
    input  logic       div_tick,
    output logic [7:0] scale,
    output logic       scale_upd,
    output logic [1:0] step_idx,
    output logic       busy,
    output logic       done,
    output logic       cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] tbl_q [0:3];
    logic [7:0] tbl_d [0:3];
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] scale_q, scale_d;
    logic [1:0] step_q, step_d;
    logic       upd_q, upd_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic [7:0] dwell_eff_s;
    logic [7:0] term_s;
    logic       at_term_s;
    logic [1:0] next_idx_s;
    logic       advance_s;

    // Terminal count for the current step; a dwell of 0 behaves as 1. The
    // compare uses >= so a dwell lowered mid-step still ends that step
    // instead of letting the counter run on to 255 and wrap.
    always_comb begin
        dwell_eff_s = (dwell == 8'd0) ? 8'd1 : dwell;
        term_s      = dwell_eff_s - 8'd1;
        at_term_s   = (cnt_q >= term_s);
    end

    // Next-state, table-write and output logic for the sequencer.
    always_comb begin
        state_d    = state_q;
        tbl_d      = tbl_q;
        cnt_d      = cnt_q;
        scale_d    = scale_q;
        step_d     = step_q;
        upd_d      = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        next_idx_s = 2'd0;
        advance_s  = 1'b0;

        // The table may only be written while idle; a write while busy is
        // rejected and flagged.
        if (cfg_we) begin
            if (state_q != ST_IDLE) begin
                err_d = 1'b1;
            end else begin
                tbl_d[cfg_addr] = cfg_data;
            end
        end else begin
            err_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // Stop wins over start; neither does anything on its own here.
                if (start && !stop) begin
                    advance_s  = 1'b1;
                    next_idx_s = 2'd0;
                    state_d    = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (div_tick) begin
                    if (at_term_s) begin
                        if (step_q < last_idx) begin
                            advance_s  = 1'b1;
                            next_idx_s = step_q + 2'd1;
                        end else if (loop_en) begin
                            advance_s  = 1'b1;
                            next_idx_s = 2'd0;
                        end else begin
                            // One-shot sequence finished; keep the last scale.
                            done_d  = 1'b1;
                            cnt_d   = 8'd0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
                // A stop request still lets a coinciding step update happen
                // before the sequencer waits for the next period boundary.
                if (stop && (state_d == ST_RUN)) begin
                    state_d = ST_STOPPING;
                end else begin
                    state_d = state_d;
                end
            end
            ST_STOPPING: begin
                if (div_tick) begin
                    done_d  = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOPPING;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        // Apply a table entry; the update pulse is only raised when the value
        // actually changes.
        if (advance_s) begin
            step_d  = next_idx_s;
            scale_d = tbl_q[next_idx_s];
            upd_d   = (tbl_q[next_idx_s] != scale_q);
            cnt_d   = 8'd0;
        end else begin
            step_d = step_d;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // Sequencer state, table and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < 4; i++) begin
                tbl_q[i] <= 8'd0;
            end
            cnt_q   <= 8'd0;
            scale_q <= 8'd0;
            step_q  <= 2'd0;
            upd_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            for (int i = 0; i < 4; i++) begin
                tbl_q[i] <= tbl_d[i];
            end
            cnt_q   <= cnt_d;
            scale_q <= scale_d;
            step_q  <= step_d;
            upd_q   <= upd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign scale     = scale_q;
    assign scale_upd = upd_q;
    assign step_idx  = step_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = err_q;

endmodule

// File: doc/clock_divider_seq.md
CLOCK_DIVIDER_SEQ -- requirements
Module: clock_divider_seq

Interface
REQ-001 SHALL have port clk  in  1  single system clock; all state rising-edge clocked.
REQ-002 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port cfg_we  in  1  table write strobe.
REQ-004 SHALL have port cfg_addr  in  2  table entry index 0..3.
REQ-005 SHALL have port cfg_data  in  8  scale value to store.
REQ-006 SHALL have port last_idx  in  2  index of final step in sequence.
REQ-007 SHALL have port dwell  in  8  divided-clock periods per step; 0 treated as 1.
REQ-008 SHALL have port loop_en  in  1  1 = wrap to entry 0 after last step; 0 = one-shot.
REQ-009 SHALL have port start  in  1  one-cycle start request.
REQ-010 SHALL have port stop  in  1  one-cycle stop request.
REQ-011 SHALL have port div_tick  in  1  one-cycle pulse from divider marking end of each output period.
REQ-012 SHALL have port scale  out  8  scale value driven to divider.
REQ-013 SHALL have port scale_upd  out  1  one-cycle pulse in the cycle scale changes.
REQ-014 SHALL have port step_idx  out  2  index of entry currently applied.
REQ-015 SHALL have port busy  out  1  high in RUN and STOPPING.
REQ-016 SHALL have port done  out  1  one-cycle pulse on sequence completion or stop completion.
REQ-017 SHALL have port cfg_err  out  1  one-cycle pulse when cfg_we is rejected.

Function
REQ-018 SHALL hold a 4 x 8-bit scale table written at cfg_addr on cfg_we only while busy=0.
REQ-019 SHALL ignore cfg_we while busy=1, leave the table unchanged and pulse cfg_err the next cycle.
REQ-020 SHALL implement FSM states IDLE, RUN, STOPPING.
REQ-021 SHALL, in IDLE on start=1 and stop=0, register the next cycle: scale=table[0], step_idx=0, scale_upd=1, dwell counter=0, state RUN.
REQ-022 SHALL give stop priority over start when both are high in IDLE; neither has any effect.
REQ-023 SHALL, in RUN, increment the dwell counter on each div_tick and change scale only in the cycle after a div_tick (period boundary, glitch-free handoff).
REQ-024 SHALL, when div_tick arrives with counter = max(dwell,1)-1 and step_idx < last_idx, register the next cycle: step_idx+1, scale=table[step_idx+1], scale_upd=1, counter=0.
REQ-025 SHALL, at the same boundary with step_idx = last_idx and loop_en=1, wrap: step_idx=0, scale=table[0], scale_upd=1, counter=0.
REQ-026 SHALL, at the same boundary with step_idx = last_idx and loop_en=0, pulse done, enter IDLE, and hold scale and step_idx unchanged.
REQ-027 SHALL suppress scale_upd when the newly applied value equals the current scale; step_idx still advances.
REQ-028 SHALL sample dwell, last_idx and loop_en continuously; a change takes effect at the next boundary comparison.
REQ-029 SHALL, on stop in RUN, enter STOPPING; on the next div_tick pulse done, enter IDLE and hold scale.
REQ-030 SHALL, when stop and a step-boundary div_tick coincide in RUN, perform the step update and then enter STOPPING.
REQ-031 SHALL ignore start while busy=1.
REQ-032 SHALL keep the dwell counter 8 bits wide with no overflow, given the terminal compare in REQ-024.

Reset
REQ-033 SHALL, on rst_n=0 at any time including mid-sequence, asynchronously clear: state IDLE, table entries 0, counter 0, scale 0, step_idx 0, scale_upd 0, busy 0, done 0, cfg_err 0.
REQ-034 SHALL resume operation at the first rising clk edge after rst_n deasserts; no start is retained across reset.

Verification
REQ-035 SHALL cover: table {4,8,16,32}, last_idx=3, dwell=2, loop_en=0, start -> scale 4,8,16,32, each changing one cycle after every 2nd div_tick; 4 scale_upd pulses; done once; scale holds 32.
REQ-036 SHALL cover: same table with loop_en=1 and 9 step boundaries -> step_idx 0,1,2,3,0,1,2,3,0,1; busy stays 1; no done.
REQ-037 SHALL cover: stop mid-step with no div_tick for 5 cycles -> scale unchanged, busy=1 until the next div_tick, then done pulse, busy=0.
REQ-038 SHALL cover: cfg_we to addr 1 with data 0xAA while busy -> cfg_err pulse, table[1] unchanged at the next run.
REQ-039 SHALL cover: dwell=0 -> scale advances after every div_tick; start and stop together in IDLE -> no state change.
REQ-040 SHALL cover: rst_n asserted in RUN at step 2 -> scale=0, busy=0 immediately, without waiting for clk; table cleared.
